uart_sensor_rx: RTL and testbench
=================================

// Module: uart_sensor_rx
// PURPOSE
//   Receives the simulator's obstacle-detector status over the UART rx line (8N1, LSB first).
//   Decodes tagged status bytes into registered front/back/left/right detector flags.
//   Tracks link liveness for the GTR top level, feeding the manual, semi-auto and auto mode logic.
//   It is the receiving end of the serial link whose transmit side carries the car control signals.
// PARAMETERS
//   CLK_FREQ        100_000_000  system clock frequency in Hz
//   BAUD            9600         serial bit rate
//   CLKS_PER_BIT    CLK_FREQ/BAUD  derived localparam; must be >= 8
//   LINK_TIMEOUT    10_000_000   cycles without a valid status frame before link_alive drops
// PORTS
//   clk             in   1  system clock (P17)
//   rst             in   1  asynchronous, active-high reset
//   rx              in   1  serial input (N5); idle high; asynchronous to clk
//   rx_data         out  8  last correctly framed byte
//   byte_valid      out  1  one-cycle pulse when rx_data updates
//   frame_error     out  1  one-cycle pulse on a bad stop bit
//   front_detector  out  1  obstacle ahead
//   back_detector   out  1  obstacle behind
//   left_detector   out  1  obstacle to the left
//   right_detector  out  1  obstacle to the right
//   link_alive      out  1  a valid status frame arrived within the last LINK_TIMEOUT cycles
// BEHAVIOUR
//   Reset (async, rst=1):
//     - All outputs are 0.
//     - Synchroniser flops are 1.
//     - FSM is in IDLE; all counters are 0.
//   Input: rx passes through a 2-FF synchroniser; all logic uses the synchronised rx_s.
//   FSM states: IDLE, START, DATA, STOP, BREAK.
//     IDLE -> START: on rx_s==0; bit counter clears.
//     START: waits CLKS_PER_BIT/2 cycles, then re-samples rx_s.
//       - 0: go to DATA.
//       - 1: glitch; return to IDLE with no pulse.
//     DATA: samples rx_s every CLKS_PER_BIT cycles (mid-bit) and shifts into bit[idx], LSB first.
//       After 8 samples, go to STOP.
//     STOP: after CLKS_PER_BIT cycles, samples rx_s.
//       - 1: rx_data <= shift reg and byte_valid=1 on the next cycle; go to IDLE.
//       - 0: frame_error=1 for one cycle, rx_data is held; go to BREAK.
//     BREAK: waits for rx_s==1, then goes to IDLE.
//   Latency: byte_valid rises 1 clk after the stop-bit sample, about 9.5 bit times after the start edge
//     (plus 2 synchroniser cycles).
//   Status frame: a byte with bits[7:4]==STATUS_TAG (4'hA).
//     - Bit mapping: bit3=front, bit2=back, bit1=left, bit0=right.
//     - Detectors update in the same cycle as byte_valid.
//     - Bytes with any other tag pulse byte_valid but leave detectors and link state unchanged.
//   Link watchdog:
//     - A 24-bit counter clears on every valid status frame and otherwise counts up, saturating at LINK_TIMEOUT.
//     - A valid status frame sets link_alive=1.
//     - When the counter reaches LINK_TIMEOUT: link_alive=0 and all four detectors are forced to 1
//       (fail-safe: all sides blocked). They hold until the next valid status frame.
//     - After reset the counter is idle: link_alive stays 0 and detectors stay 0 until the first status frame.
//   Simultaneous events: a status frame completing in the timeout cycle wins; link_alive stays 1.
//   Reset mid-frame: the frame is abandoned with no pulse. The receiver resynchronises on the next falling edge.
//   No line activity while in IDLE produces no pulses.
// STRUCTURE
//   Shared include gtr_defs.vh holds:
//     - FSM state encodings: IDLE, START, DATA, STOP, BREAK (3-bit).
//     - STATUS_TAG = 4'hA.
//     - Detector bit indices.
//     - Default CLK_FREQ/BAUD.
//   One sub-module, uart_rx_core: synchroniser, bit FSM, rx_data/byte_valid/frame_error.
//   The top of this block adds the tag decode, detector registers and watchdog.
// TESTING (bench: CLK_FREQ=160_000, BAUD=10_000 -> CLKS_PER_BIT=16; LINK_TIMEOUT=1000)
//   1. Reset with rx=1:
//      -> all outputs 0 during and after reset; no pulses for 500 cycles.
//   2. Send 0xA5:
//      -> byte_valid for exactly 1 cycle with rx_data=0xA5.
//      -> back=1, right=1, front=0, left=0; link_alive=1.
//   3. Send 0x3C after test 2:
//      -> byte_valid, rx_data=0x3C; detectors and link_alive unchanged.
//   4. rx low for 4 cycles, then high:
//      -> no byte_valid, no frame_error; a following 0xA0 is received correctly.
//   5. Send 0xAF with stop bit 0, held low for 3 bit times, then idle:
//      -> frame_error 1 cycle, no byte_valid, detectors unchanged; the next 0xA1 is accepted.
//   6. After 0xA2, send nothing:
//      -> link_alive falls exactly 1000 cycles after that byte_valid, detectors become 4'b1111.
//      -> sending 0xA0 restores link_alive=1 and detectors 0.
//   7. Assert rst during DATA of a frame:
//      -> outputs 0 immediately (asynchronous); the next full 0xA8 frame decodes front=1.

Source files
------------

// File: rtl/uart_sensor_rx_pkg.sv
// uart_sensor_rx_pkg: shared state encoding, status tag, detector bit indices, default rates
package uart_sensor_rx_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4} rx_state_e;
  localparam logic [3:0] STATUS_TAG = 4'hA;
  localparam int FRONT_BIT = 3;
  localparam int BACK_BIT = 2;
  localparam int LEFT_BIT = 1;
  localparam int RIGHT_BIT = 0;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD = 9600;
  localparam int DEF_LINK_TIMEOUT = 10_000_000;
  function automatic logic is_status(input logic [7:0] b);
    return b[7:4] == STATUS_TAG;
  endfunction
endpackage

// File: rtl/uart_sensor_rx_if.sv
// uart_sensor_rx_if: serial rx line in, received byte/pulses/detector flags/link_alive out
interface uart_sensor_rx_if;
  logic rx;
  logic [7:0] rx_data;
  logic byte_valid;
  logic frame_error;
  logic front_detector;
  logic back_detector;
  logic left_detector;
  logic right_detector;
  logic link_alive;
  modport slave (input rx, output rx_data, byte_valid, frame_error, front_detector, back_detector, left_detector, right_detector, link_alive);
  modport master (output rx, input rx_data, byte_valid, frame_error, front_detector, back_detector, left_detector, right_detector, link_alive);
endinterface

// File: rtl/uart_sensor_rx_core.sv
// uart_sensor_rx_core: 2-FF synchroniser + 8N1 bit FSM; byte_done_o/byte_o give the byte one cycle ahead of byte_valid_o
module uart_sensor_rx_core
  import uart_sensor_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       byte_valid_o,
  output logic       frame_error_o,
  output logic       byte_done_o,
  output logic [7:0] byte_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state_q, state_d;
  logic meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic bv_q, bv_d, fe_q, fe_d, tick;
  assign tick = cnt_q == (state_q == START ? HALF : FULL);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {meta_q, rx_s_q} <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      rx_data_q <= '0;
      bv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      {meta_q, rx_s_q} <= {rx_i, meta_q};
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      rx_data_q <= rx_data_d;
      bv_q <= bv_d;
      fe_q <= fe_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rx_s_q ? IDLE : START;
      START:   state_d = tick ? (rx_s_q ? IDLE : DATA) : START;
      DATA:    state_d = (tick && idx_q == 3'd7) ? STOP : DATA;
      STOP:    state_d = tick ? (rx_s_q ? IDLE : BREAK) : STOP;
      BREAK:   state_d = rx_s_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = (state_q inside {START, DATA, STOP}) && !tick ? cnt_q + CW'(1) : '0;
    idx_d = state_q == DATA ? idx_q + {2'b00, tick} : '0;
    shift_d = (state_q == DATA && tick) ? {rx_s_q, shift_q[7:1]} : shift_q;
    byte_done_o = state_q == STOP && tick && rx_s_q;
    fe_d = state_q == STOP && tick && !rx_s_q;
    bv_d = byte_done_o;
    rx_data_d = byte_done_o ? shift_q : rx_data_q;
  end
  assign byte_o = shift_q;
  assign rx_data_o = rx_data_q;
  assign byte_valid_o = bv_q;
  assign frame_error_o = fe_q;
endmodule

// File: rtl/uart_sensor_rx.sv
// uart_sensor_rx: clk/rst + bus (slave); decodes 0xA? status bytes into detector flags with a fail-safe link watchdog
module uart_sensor_rx
  import uart_sensor_rx_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int LINK_TIMEOUT = DEF_LINK_TIMEOUT
) (
  input logic clk,
  input logic rst,
  uart_sensor_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [23:0] TO = 24'(LINK_TIMEOUT);
  logic done, status, timeout;
  logic [7:0] byte_w;
  logic [23:0] wd_q, wd_d;
  logic armed_q, armed_d, link_q, link_d;
  logic [3:0] det_q, det_d;
  uart_sensor_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk(clk),
    .rst(rst),
    .rx_i(bus.rx),
    .rx_data_o(bus.rx_data),
    .byte_valid_o(bus.byte_valid),
    .frame_error_o(bus.frame_error),
    .byte_done_o(done),
    .byte_o(byte_w)
  );
  assign status = done && is_status(byte_w);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_q <= '0;
      armed_q <= 1'b0;
      link_q <= 1'b0;
      det_q <= '0;
    end else begin
      wd_q <= wd_d;
      armed_q <= armed_d;
      link_q <= link_d;
      det_q <= det_d;
    end
  always_comb begin
    wd_d = status ? '0 : (armed_q && wd_q != TO ? wd_q + 24'd1 : wd_q);
    timeout = !status && armed_q && wd_d == TO;
    armed_d = armed_q | status;
    link_d = status ? 1'b1 : (timeout ? 1'b0 : link_q);
    det_d = status ? byte_w[3:0] : (timeout ? 4'hF : det_q);
  end
  assign bus.front_detector = det_q[FRONT_BIT];
  assign bus.back_detector = det_q[BACK_BIT];
  assign bus.left_detector = det_q[LEFT_BIT];
  assign bus.right_detector = det_q[RIGHT_BIT];
  assign bus.link_alive = link_q;
endmodule

// File: tb/tb_uart_sensor_rx.sv
// tb_uart_sensor_rx: random and directed frames checked every cycle against a timeline model of the receiver
module tb_uart_sensor_rx;
  localparam int CPB = 16;
  localparam int TO = 1000;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
  typedef struct {
    int c;
    logic [7:0] d;
    bit ok;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_sensor_rx_if u_if ();
  uart_sensor_rx #(.CLK_FREQ(160_000), .BAUD(10_000), .LINK_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int bv_cyc = 0;
  logic [7:0] bv_data;
  logic [3:0] bv_det;
  logic bv_link;
  logic [3:0] dut_det;
  assign dut_det = {u_if.front_detector, u_if.back_detector, u_if.left_detector, u_if.right_detector};
  ev_t q[$];
  ev_t ev;
  logic [7:0] m_data;
  logic [3:0] m_det;
  logic m_link, m_bv, m_fe, m_armed;
  bit m_st;
  int m_wd;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", n, cyc, a, e);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_det = '0;
    m_link = 1'b0;
    m_bv = 1'b0;
    m_fe = 1'b0;
    m_armed = 1'b0;
    m_wd = 0;
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) begin
      m_bv = 1'b0;
      m_fe = 1'b0;
      m_st = 1'b0;
      while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].c == cyc) begin
        ev = q.pop_front();
        if (ev.ok) begin
          m_bv = 1'b1;
          m_data = ev.d;
          if (ev.d[7:4] == 4'hA) begin
            m_st = 1'b1;
            m_det = ev.d[3:0];
            m_link = 1'b1;
            m_armed = 1'b1;
            m_wd = 0;
          end
        end else m_fe = 1'b1;
      end
      if (!m_st && m_armed && m_wd < TO) begin
        m_wd++;
        if (m_wd == TO) begin
          m_link = 1'b0;
          m_det = 4'hF;
        end
      end
    end
    if (u_if.byte_valid) begin
      bv_cnt++;
      bv_cyc = cyc;
      bv_data = u_if.rx_data;
      bv_det = dut_det;
      bv_link = u_if.link_alive;
    end
    if (u_if.frame_error) fe_cnt++;
    chk("byte_valid", 32'(u_if.byte_valid), 32'(m_bv));
    chk("frame_error", 32'(u_if.frame_error), 32'(m_fe));
    chk("rx_data", 32'(u_if.rx_data), 32'(m_data));
    chk("detectors", 32'(dut_det), 32'(m_det));
    chk("link_alive", 32'(u_if.link_alive), 32'(m_link));
  end
  task automatic send_frame(input logic [7:0] d, input bit ok);
    logic [9:0] f;
    f = {ok, d, 1'b0};
    @(negedge clk);
    q.push_back('{c: cyc + LAT, d: d, ok: ok});
    for (int i = 0; i < 10; i++) begin
      u_if.rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    if (!ok) repeat (2 * CPB) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end
  initial begin
    logic [7:0] d;
    bit ok;
    u_if.rx = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    chk("idle_bv_count", 32'(bv_cnt), 0);
    chk("idle_fe_count", 32'(fe_cnt), 0);
    chk("idle_link", 32'(u_if.link_alive), 0);
    send_frame(8'hA5, 1'b1);
    chk("a5_count", 32'(bv_cnt), 1);
    chk("a5_data", 32'(bv_data), 32'h A5);
    chk("a5_det", 32'(bv_det), 32'b0101);
    chk("a5_link", 32'(bv_link), 1);
    send_frame(8'h3C, 1'b1);
    chk("3c_count", 32'(bv_cnt), 2);
    chk("3c_data", 32'(bv_data), 32'h3C);
    chk("3c_det_held", 32'(dut_det), 32'b0101);
    chk("3c_link_held", 32'(u_if.link_alive), 1);
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_bv", 32'(bv_cnt), 2);
    chk("glitch_no_fe", 32'(fe_cnt), 0);
    send_frame(8'hA0, 1'b1);
    chk("a0_count", 32'(bv_cnt), 3);
    chk("a0_data", 32'(bv_data), 32'hA0);
    chk("a0_det", 32'(bv_det), 0);
    send_frame(8'hAF, 1'b0);
    chk("ferr_count", 32'(fe_cnt), 1);
    chk("ferr_no_bv", 32'(bv_cnt), 3);
    chk("ferr_det_held", 32'(dut_det), 0);
    chk("ferr_data_held", 32'(u_if.rx_data), 32'hA0);
    send_frame(8'hA1, 1'b1);
    chk("a1_count", 32'(bv_cnt), 4);
    chk("a1_det", 32'(bv_det), 32'b0001);
    send_frame(8'hA2, 1'b1);
    chk("a2_det", 32'(bv_det), 32'b0010);
    for (int i = 0; i < 1200 && u_if.link_alive; i++) begin
      @(posedge clk);
      #2;
    end
    chk("wd_fall", 32'(u_if.link_alive), 0);
    chk("wd_delay", 32'(cyc - bv_cyc), TO);
    chk("wd_failsafe_det", 32'(dut_det), 32'hF);
    send_frame(8'hA0, 1'b1);
    chk("wd_restore_link", 32'(u_if.link_alive), 1);
    chk("wd_restore_det", 32'(dut_det), 0);
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (CPB + 8) @(negedge clk);
    #2;
    rst = 1'b1;
    u_if.rx = 1'b1;
    model_reset();
    #1;
    chk("async_rst_link", 32'(u_if.link_alive), 0);
    chk("async_rst_data", 32'(u_if.rx_data), 0);
    chk("async_rst_det", 32'(dut_det), 0);
    chk("async_rst_bv", 32'(u_if.byte_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'hA8, 1'b1);
    chk("a8_data", 32'(bv_data), 32'hA8);
    chk("a8_det", 32'(bv_det), 32'b1000);
    chk("a8_link", 32'(bv_link), 1);
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) d[7:4] = 4'hA;
      ok = $urandom_range(7, 0) != 0;
      send_frame(d, ok);
      repeat ($urandom_range(20, 0)) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    chk("pending_events", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
